// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction prefetch queue in front of a synchronous ROM.
//
// Issues sequential ROM reads from fetch_pc. Each returned word is tagged with
// its PC and held in a DEPTH-entry FIFO. Decode consumes entries through a
// valid/ready handshake. A downstream redirect flushes the queue, drops any
// read still in flight, and restarts fetch at the target address.
//
// Optional feature (compile-time macro IFETCH_MISALIGN_EN):
//   defined   -> a redirect to a non-word-aligned target raises the sticky
//                misalign_err flag and halts issue until an aligned redirect
//                or a reset arrives.
//   undefined -> misalign_err is tied low, and redirect_pc[1:0] are ignored.
//
// Ports:
//   clock, reset        single clock; synchronous active-high reset
//   imem_en, imem_addr  ROM read request and word address (fetch_pc[ADDR_W-1:2])
//   imem_data           ROM data, valid the cycle after imem_en
//   redirect, redirect_pc
//                       taken control transfer from downstream, with its target
//   out_valid, out_ready, out_instr, out_pc, out_pc_plus_4
//                       decode-side handshake from the queue head
//   fetch_pc            address of the next read to issue
//   misalign_err        sticky misaligned-redirect flag
module ifetch_queue #(
    parameter int          ADDR_W   = 16,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_en,
    output logic [ADDR_W-3:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc_plus_4,
    output logic [31:0]       fetch_pc,
    output logic              misalign_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          halt;
    logic          issue;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_target;

`ifdef IFETCH_MISALIGN_EN
    logic misalign_q;

    assign redirect_target = redirect_pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (redirect) begin
            misalign_q <= |redirect_pc[1:0];
        end
    end

    assign halt         = misalign_q;
    assign misalign_err = misalign_q;
`else
    logic unused_low_bits;

    assign unused_low_bits = &{1'b0, redirect_pc[1:0]};
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign halt            = 1'b0;
    assign misalign_err    = 1'b0;
`endif

    // The read in flight is counted against capacity, so a full queue never
    // receives data it cannot hold.
    always_comb begin
        occupancy = count + CW'(inflight);
        issue     = !reset && !halt && !redirect && (occupancy < CW'(DEPTH));
        out_valid = !reset && (count != '0);
        push      = inflight && !redirect;
        pop       = out_valid && out_ready;
    end

    assign imem_en       = issue;
    assign imem_addr     = fetch_pc[ADDR_W-1:2];
    assign out_instr     = q_instr[head];
    assign out_pc        = q_pc[head];
    assign out_pc_plus_4 = out_pc + 32'd4;

    // Control state. Reset and redirect share the flush path. Reset has priority
    // over redirect. A pop that coincides with a redirect is simply absorbed by
    // the flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_target;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Datapath storage needs no reset, because validity is tracked by count
    // and inflight.
    always_ff @(posedge clock) begin
        if (issue) begin
            inflight_pc <= fetch_pc;
        end
        if (!reset && push) begin
            q_instr[tail] <= imem_data;
            q_pc[tail]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance: ADDR_W=16, DEPTH=4, RESET_PC=0
    logic        reset = 1'b1;
    logic        imem_en;
    logic [13:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr, out_pc, out_pc_plus_4, fetch_pc;
    logic        misalign_err;

    ifetch_queue #(.ADDR_W(16), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .fetch_pc(fetch_pc),
        .misalign_err(misalign_err)
    );

    // ROM model: word i holds the value i
    always @(posedge clock) if (imem_en) imem_data <= 32'(imem_addr);

    // Narrow instance for address-wrap checks: ADDR_W=8, RESET_PC=0x20
    logic        reset2 = 1'b1;
    logic        imem_en2;
    logic [5:0]  imem_addr2;
    logic [31:0] imem_data2;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] out_instr2, out_pc2, out_pc_plus_42, fetch_pc2;
    logic        misalign_err2;

    ifetch_queue #(.ADDR_W(8), .DEPTH(4), .RESET_PC(32'h0000_0020)) dut2 (
        .clock(clock), .reset(reset2), .imem_en(imem_en2), .imem_addr(imem_addr2),
        .imem_data(imem_data2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_pc(out_pc2), .out_pc_plus_4(out_pc_plus_42), .fetch_pc(fetch_pc2),
        .misalign_err(misalign_err2)
    );

    always @(posedge clock) if (imem_en2) imem_data2 <= 32'(imem_addr2);

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        en;
        logic        ca;    // check imem_addr in this cycle
        logic [13:0] addr;
        logic        vld;
        logic [31:0] pc;    // expected head pc; expected instr = pc/4 (ROM rule)
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic rdy, input logic en, input logic ca,
                                input int addr, input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.en = en; v.ca = ca; v.addr = 14'(addr); v.vld = vld; v.pc = pc;
        return v;
    endfunction

    vec_t vecs [27];

    initial begin
        int n;
        // reset, then streaming with out_ready=1
        vecs[0]  = mk(1, 0, 32'h0,  1, 0, 0, 0,    0, 32'h0);
        vecs[1]  = mk(1, 0, 32'h0,  1, 0, 1, 0,    0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,  1, 1, 1, 0,    0, 32'h0);
        vecs[3]  = mk(0, 0, 32'h0,  1, 1, 1, 1,    0, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0,  1, 1, 1, 2,    1, 32'h0);
        vecs[5]  = mk(0, 0, 32'h0,  1, 1, 1, 3,    1, 32'h4);
        vecs[6]  = mk(0, 0, 32'h0,  1, 1, 1, 4,    1, 32'h8);
        // mid-operation reset, then fill with out_ready=0
        vecs[7]  = mk(1, 0, 32'h0,  0, 0, 1, 5,    0, 32'h0);
        vecs[8]  = mk(0, 0, 32'h0,  0, 1, 1, 0,    0, 32'h0);
        vecs[9]  = mk(0, 0, 32'h0,  0, 1, 1, 1,    0, 32'h0);
        vecs[10] = mk(0, 0, 32'h0,  0, 1, 1, 2,    1, 32'h0);
        vecs[11] = mk(0, 0, 32'h0,  0, 1, 1, 3,    1, 32'h0);
        vecs[12] = mk(0, 0, 32'h0,  0, 0, 1, 4,    1, 32'h0);
        vecs[13] = mk(0, 0, 32'h0,  0, 0, 1, 4,    1, 32'h0);
        // drain in order
        vecs[14] = mk(0, 0, 32'h0,  1, 0, 1, 4,    1, 32'h0);
        vecs[15] = mk(0, 0, 32'h0,  1, 1, 1, 4,    1, 32'h4);
        vecs[16] = mk(0, 0, 32'h0,  1, 1, 1, 5,    1, 32'h8);
        vecs[17] = mk(0, 0, 32'h0,  1, 1, 1, 6,    1, 32'hC);
        vecs[18] = mk(0, 0, 32'h0,  0, 1, 1, 7,    1, 32'h10);
        // redirect with a loaded queue and a read in flight
        vecs[19] = mk(0, 1, 32'h40, 0, 0, 1, 8,    1, 32'h10);
        vecs[20] = mk(0, 0, 32'h0,  0, 1, 1, 16,   0, 32'h0);
        vecs[21] = mk(0, 0, 32'h0,  0, 1, 1, 17,   0, 32'h0);
        vecs[22] = mk(0, 0, 32'h0,  1, 1, 1, 18,   1, 32'h40);
        // redirect coinciding with a pop
        vecs[23] = mk(0, 1, 32'h80, 1, 0, 1, 19,   1, 32'h44);
        vecs[24] = mk(0, 0, 32'h0,  1, 1, 1, 32,   0, 32'h0);
        vecs[25] = mk(0, 0, 32'h0,  1, 1, 1, 33,   0, 32'h0);
        vecs[26] = mk(0, 0, 32'h0,  1, 1, 1, 34,   1, 32'h80);

        for (int i = 0; i < 27; i++) begin
            reset = vecs[i].rst; redirect = vecs[i].redir;
            redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
            @(negedge clock);
            chk($sformatf("v%0d imem_en", i), 32'(imem_en), 32'(vecs[i].en));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].vld));
            if (vecs[i].ca)
                chk($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
            if (vecs[i].vld) begin
                chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].pc);
                chk($sformatf("v%0d out_instr", i), out_instr, vecs[i].pc >> 2);
                chk($sformatf("v%0d out_pc_plus_4", i), out_pc_plus_4, vecs[i].pc + 32'd4);
            end
            chk($sformatf("v%0d misalign_err", i), 32'(misalign_err), 32'd0);
            tick;
        end

        // misaligned redirect target
        redirect = 1'b1; redirect_pc = 32'h42; out_ready = 1'b1;
        @(negedge clock);
        chk("mis redirect imem_en", 32'(imem_en), 32'd0);
        chk("mis redirect head pc", out_pc, 32'h84);
        tick;
        redirect = 1'b0;
`ifdef IFETCH_MISALIGN_EN
        @(negedge clock);
        chk("mis err set", 32'(misalign_err), 32'd1);
        chk("mis halted imem_en", 32'(imem_en), 32'd0);
        chk("mis fetch_pc", fetch_pc, 32'h42);
        for (int k = 0; k < 2; k++) begin
            tick;
            @(negedge clock);
            chk("mis still halted", 32'(imem_en), 32'd0);
            chk("mis no output", 32'(out_valid), 32'd0);
        end
        tick;
        redirect = 1'b1; redirect_pc = 32'h44;
        @(negedge clock);
        tick;
        redirect = 1'b0;
        @(negedge clock);
        chk("mis err cleared", 32'(misalign_err), 32'd0);
        chk("mis resume imem_en", 32'(imem_en), 32'd1);
        chk("mis resume addr", 32'(imem_addr), 32'h11);
        n = 0;
        while (!out_valid && n < 10) begin tick; @(negedge clock); n++; end
        chk("mis resume latency", 32'(n), 32'd2);
        chk("mis resume out_pc", out_pc, 32'h44);
        chk("mis resume out_instr", out_instr, 32'h11);
`else
        @(negedge clock);
        chk("mis err tied low", 32'(misalign_err), 32'd0);
        chk("mis fetch_pc aligned", fetch_pc, 32'h40);
        chk("mis imem_en", 32'(imem_en), 32'd1);
        chk("mis addr", 32'(imem_addr), 32'h10);
        n = 0;
        while (!out_valid && n < 10) begin tick; @(negedge clock); n++; end
        chk("mis latency", 32'(n), 32'd2);
        chk("mis out_pc", out_pc, 32'h40);
        chk("mis out_instr", out_instr, 32'h10);
`endif

        // narrow instance: reset start address and word-address wrap
        reset2 = 1'b1; out_ready2 = 1'b1;
        @(negedge clock);
        chk("w reset imem_en", 32'(imem_en2), 32'd0);
        chk("w reset out_valid", 32'(out_valid2), 32'd0);
        tick;
        reset2 = 1'b0;
        @(negedge clock);
        chk("w first imem_en", 32'(imem_en2), 32'd1);
        chk("w first addr", 32'(imem_addr2), 32'd8);
        tick;
        redirect2 = 1'b1; redirect_pc2 = 32'hFC;
        @(negedge clock);
        chk("w redirect imem_en", 32'(imem_en2), 32'd0);
        tick;
        redirect2 = 1'b0;
        @(negedge clock);
        chk("w addr 63", 32'(imem_addr2), 32'd63);
        chk("w fetch_pc FC", fetch_pc2, 32'hFC);
        tick;
        @(negedge clock);
        chk("w addr wrap", 32'(imem_addr2), 32'd0);
        chk("w fetch_pc 100", fetch_pc2, 32'h100);
        chk("w still empty", 32'(out_valid2), 32'd0);
        tick;
        @(negedge clock);
        chk("w out_valid", 32'(out_valid2), 32'd1);
        chk("w out_pc FC", out_pc2, 32'hFC);
        chk("w out_instr 63", out_instr2, 32'd63);
        chk("w out_pc_plus_4", out_pc_plus_42, 32'h100);
        tick;
        @(negedge clock);
        chk("w out_pc 100", out_pc2, 32'h100);
        chk("w out_instr 0", out_instr2, 32'd0);
        chk("w misalign_err", 32'(misalign_err2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
